// File: rtl/seq_div32x16_if.sv
// Operand/result handshake bundle for seq_div32x16.
// master drives operands and result acceptance; slave is the divider.
interface seq_div32x16_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_div32x16.sv
// Sequential unsigned 32/16 restoring divider, one quotient bit per cycle.
// Single-issue: a new operand pair is taken only after the result is consumed.
module seq_div32x16 (
  input  logic            clk,
  input  logic            rst_n,
  seq_div32x16_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] q;
  logic [15:0] rem;
  logic [15:0] dsr;
  logic        dbz;
  logic        in_rdy;
  logic        out_vld;

  logic [16:0] trial;
  logic [16:0] diff;
  logic        ge;
  logic [16:0] rem_nxt;
  logic        unused_msb;

  // q holds the unconsumed dividend bits at its MSB end and
  // collects quotient bits at its LSB end as they are produced.
  always_comb begin
    trial      = {rem, q[31]};
    diff       = trial - {1'b0, dsr};
    ge         = (trial >= {1'b0, dsr});
    rem_nxt    = ge ? diff : trial;
    unused_msb = rem_nxt[16];
  end

  // Control FSM and datapath registers with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      q       <= 32'd0;
      rem     <= 16'd0;
      dsr     <= 16'd0;
      dbz     <= 1'b0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_rdy <= 1'b0;
            if (bus.divisor == 16'd0) begin
              q       <= 32'hFFFF_FFFF;
              rem     <= bus.dividend[15:0];
              dsr     <= 16'd0;
              dbz     <= 1'b1;
              out_vld <= 1'b1;
              state   <= DONE;
            end else begin
              q     <= bus.dividend;
              rem   <= 16'd0;
              dsr   <= bus.divisor;
              dbz   <= 1'b0;
              cnt   <= 5'd31;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q   <= {q[30:0], ge};
          rem <= rem_nxt[15:0];
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            out_vld <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          out_vld <= 1'b0;
          in_rdy  <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = out_vld;
  assign bus.quotient    = q;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_div32x16.sv
// Self-checking bench for seq_div32x16 against a plain-arithmetic model.
// Latency is counted in rising edges from the accept edge inclusive.
module tb_seq_div32x16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  seq_div32x16_if bus ();

  seq_div32x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [15:0] b);
    if (b == 16'd0) return 32'hFFFF_FFFF;
    return a / {16'd0, b};
  endfunction

  function automatic logic [15:0] ref_r(input logic [31:0] a, input logic [15:0] b);
    logic [31:0] m;
    if (b == 16'd0) return a[15:0];
    m = a % {16'd0, b};
    return m[15:0];
  endfunction

  function automatic int ref_lat(input logic [15:0] b);
    return (b == 16'd0) ? 1 : 33;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents an operand pair, waits for the result; leaves the DUT in DONE.
  task automatic start_op(input logic [31:0] a, input logic [15:0] b,
                          input bit noisy, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.out_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (noisy) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
    end while (!bus.out_valid && lat < 100);
  endtask

  task automatic consume();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.quotient !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_quotient got %h want 0", bus.quotient);
    end
    n_cmp++;
    if (bus.remainder !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_remainder got %h want 0", bus.remainder);
    end
    n_cmp++;
    if (bus.div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_dbz got %b want 0", bus.div_by_zero);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [4];
    logic [15:0] vb [4];
    logic [31:0] eq [4];
    logic [15:0] er [4];
    int lat;
    va = '{32'hFFFE_0001, 32'h0000_0064, 32'hDEAD_BEEF, 32'h1234_5678};
    vb = '{16'hFFFF, 16'h0007, 16'h0001, 16'h0000};
    eq = '{32'h0000_FFFF, 32'h0000_000E, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    er = '{16'h0000, 16'h0002, 16'h0000, 16'h5678};
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], 1'b0, lat);
      n_cmp++;
      if (lat !== ref_lat(vb[i])) begin
        n_bad++;
        $display("FAIL vec%0d_latency got %0d want %0d", i, lat, ref_lat(vb[i]));
      end
      n_cmp++;
      if (bus.quotient !== eq[i]) begin
        n_bad++;
        $display("FAIL vec%0d_quotient got %h want %h", i, bus.quotient, eq[i]);
      end
      n_cmp++;
      if (bus.remainder !== er[i]) begin
        n_bad++;
        $display("FAIL vec%0d_remainder got %h want %h", i, bus.remainder, er[i]);
      end
      n_cmp++;
      if (bus.div_by_zero !== (vb[i] == 16'd0)) begin
        n_bad++;
        $display("FAIL vec%0d_dbz got %b want %b", i, bus.div_by_zero, vb[i] == 16'd0);
      end
      consume();
    end
  endtask

  task automatic test_random(input int n, input bit noisy);
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] rq;
    logic [15:0] rr;
    int lat;
    int sel;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 16'd0;
        1: b = 16'd1;
        2: b = 16'hFFFF;
        3: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      rq = ref_q(a, b);
      rr = ref_r(a, b);
      start_op(a, b, noisy, lat);
      n_cmp++;
      if (lat !== ref_lat(b) || bus.quotient !== rq || bus.remainder !== rr ||
          bus.div_by_zero !== (b == 16'd0)) begin
        n_bad++;
        $display("FAIL rand %h/%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                 a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat,
                 rq, rr, b == 16'd0, ref_lat(b));
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] q0;
    logic [15:0] r0;
    logic        z0;
    int lat;
    start_op(32'h0BAD_F00D, 16'h0123, 1'b0, lat);
    q0 = bus.quotient;
    r0 = bus.remainder;
    z0 = bus.div_by_zero;
    n_cmp++;
    if (q0 !== ref_q(32'h0BAD_F00D, 16'h0123) || r0 !== ref_r(32'h0BAD_F00D, 16'h0123)) begin
      n_bad++;
      $display("FAIL bp_result got q=%h r=%h want q=%h r=%h", q0, r0,
               ref_q(32'h0BAD_F00D, 16'h0123), ref_r(32'h0BAD_F00D, 16'h0123));
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.dividend = $urandom;
      bus.divisor  = 16'($urandom);
      bus.out_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.quotient !== q0 || bus.remainder !== r0 || bus.div_by_zero !== z0 ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold%0d got q=%h r=%h z=%b ir=%b ov=%b want q=%h r=%h z=%b ir=0 ov=1",
                 i, bus.quotient, bus.remainder, bus.div_by_zero, bus.in_ready,
                 bus.out_valid, q0, r0, z0);
      end
    end
    consume();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid);
    end
    start_op(32'h0000_0064, 16'h0007, 1'b0, lat);
    n_cmp++;
    if (bus.quotient !== 32'hE || bus.remainder !== 16'h2 || lat !== 33) begin
      n_bad++;
      $display("FAIL bp_next got q=%h r=%h lat=%0d want q=e r=2 lat=33",
               bus.quotient, bus.remainder, lat);
    end
    consume();
  endtask

  task automatic test_reset_abort();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 32'hFFFF_FFFF;
    bus.divisor  = 16'h0003;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== 32'd0) begin
      n_bad++;
      $display("FAIL abort_calc got ov=%b ir=%b q=%h want ov=0 ir=1 q=0",
               bus.out_valid, bus.in_ready, bus.quotient);
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_result got ov=%b want 0", bus.out_valid);
    end
    start_op(32'h0000_0064, 16'h0007, 1'b0, lat);
    n_cmp++;
    if (bus.quotient !== 32'hE || bus.remainder !== 16'h2 || lat !== 33) begin
      n_bad++;
      $display("FAIL abort_next got q=%h r=%h lat=%0d want q=e r=2 lat=33",
               bus.quotient, bus.remainder, lat);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_done got ov=%b ir=%b z=%b want ov=0 ir=1 z=0",
               bus.out_valid, bus.in_ready, bus.div_by_zero);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = 32'd0;
    bus.divisor   = 16'd0;
    test_reset();
    test_vectors();
    test_random(40, 1'b0);
    test_random(20, 1'b1);
    test_backpressure();
    test_reset_abort();
    test_vectors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
